// File: rtl/shift_chain_pkg.sv
// Shared types and sizing helpers for the shift-register chain driver.
package shift_chain_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SH_LOW  = 3'd1,
    SH_HIGH = 3'd2,
    LATCH   = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam int PHASE_W = 8;

  function automatic int bit_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing each FSM phase; tc_o flags the last cycle of a phase.
module phase_timer
  import shift_chain_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [PHASE_W-1:0] load_val_i,
  output logic               tc_o
);

  logic [PHASE_W-1:0] count_q, count_d;

  // Saturates at zero so a phase never wraps into a second period.
  always_comb begin
    count_d = count_q;
    if (load_i)              count_d = load_val_i;
    else if (count_q != '0)  count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/shift_chain_driver.sv
// Serialises a W-bit frame into a cascade of 8-bit SIPO registers (DS/SHCP), then pulses STCP.
// All outputs are registered copies of next-state decode, so they track the FSM with no input-to-output path.
module shift_chain_driver
  import shift_chain_pkg::*;
#(
  parameter int NUM_BYTES = 2,
  parameter int CLK_DIV   = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] data,
  output logic                   ready,
  output logic                   DS,
  output logic                   SHCP,
  output logic                   STCP,
  output logic                   busy,
  output logic                   done
);

  localparam int W   = 8 * NUM_BYTES;
  localparam int BCW = bit_cnt_w(W);
  localparam logic [PHASE_W-1:0] PH_LOAD  = PHASE_W'(CLK_DIV - 1);
  localparam logic [BCW-1:0]     LAST_BIT = BCW'(W - 1);

  if (NUM_BYTES < 1 || NUM_BYTES > 16) begin : g_bad_num_bytes
    $error("shift_chain_driver: NUM_BYTES must be in 1..16");
  end
  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("shift_chain_driver: CLK_DIV must be in 1..255");
  end
  if (MSB_FIRST != 0 && MSB_FIRST != 1) begin : g_bad_msb_first
    $error("shift_chain_driver: MSB_FIRST must be 0 or 1");
  end

  state_e         state_q, state_d;
  logic [W-1:0]   sreg_q, sreg_d, shift_src;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic           ready_q, ds_q, shcp_q, stcp_q, busy_q, done_q;
  logic           ready_d, ds_d, shcp_d, stcp_d, busy_d, done_d;
  logic           ph_tc, accept, load_bit, head_bit;

  phase_timer u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (state_d != state_q),
    .load_val_i (PH_LOAD),
    .tc_o       (ph_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SH_LOW;
      SH_LOW:  if (ph_tc) state_d = SH_HIGH;
      SH_HIGH: if (ph_tc) state_d = (bcnt_q == LAST_BIT) ? LATCH : SH_LOW;
      LATCH:   if (ph_tc) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // On accept the first bit comes straight from data, since the shift register loads on the same edge.
  assign accept    = (state_q == IDLE) && start;
  assign load_bit  = (state_d == SH_LOW) && (state_q != SH_LOW);
  assign shift_src = accept ? data : sreg_q;
  assign head_bit  = (MSB_FIRST != 0) ? shift_src[W-1] : shift_src[0];

  always_comb begin
    sreg_d = sreg_q;
    bcnt_d = bcnt_q;
    if (accept)                          bcnt_d = '0;
    else if (state_q == SH_HIGH && ph_tc) bcnt_d = bcnt_q + 1'b1;
    if (load_bit) begin
      sreg_d = (MSB_FIRST != 0) ? {shift_src[W-2:0], 1'b0} : {1'b0, shift_src[W-1:1]};
    end
  end

  always_comb begin
    ready_d = 1'b0;
    ds_d    = ds_q;
    shcp_d  = 1'b0;
    stcp_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_d)
      IDLE:    begin ready_d = 1'b1; ds_d = 1'b0; end
      SH_LOW:  begin busy_d = 1'b1; if (load_bit) ds_d = head_bit; end
      SH_HIGH: begin busy_d = 1'b1; shcp_d = 1'b1; end
      LATCH:   begin busy_d = 1'b1; stcp_d = 1'b1; end
      DONE:    begin done_d = 1'b1; ds_d = 1'b0; end
      default: begin ready_d = 1'b1; ds_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg_q  <= '0;
      bcnt_q  <= '0;
      ready_q <= 1'b1;
      ds_q    <= 1'b0;
      shcp_q  <= 1'b0;
      stcp_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      ready_q <= ready_d;
      ds_q    <= ds_d;
      shcp_q  <= shcp_d;
      stcp_q  <= stcp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign DS    = ds_q;
  assign SHCP  = shcp_q;
  assign STCP  = stcp_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_shift_chain_driver.sv
// Three driver configurations checked against a frame scoreboard: bit order, done timing, strobe widths, reset abort.
module tb_shift_chain_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start [3];
  logic [15:0] data  [3];
  logic        ready [3];
  logic        ds    [3];
  logic        shcp  [3];
  logic        stcp  [3];
  logic        busy  [3];
  logic        done  [3];

  always #5 clk = ~clk;

  shift_chain_driver #(.NUM_BYTES(1), .CLK_DIV(4), .MSB_FIRST(1)) u_a (
    .clk(clk), .reset(rst_n), .start(start[0]), .data(data[0][7:0]),
    .ready(ready[0]), .DS(ds[0]), .SHCP(shcp[0]), .STCP(stcp[0]), .busy(busy[0]), .done(done[0]));

  shift_chain_driver #(.NUM_BYTES(2), .CLK_DIV(2), .MSB_FIRST(0)) u_b (
    .clk(clk), .reset(rst_n), .start(start[1]), .data(data[1]),
    .ready(ready[1]), .DS(ds[1]), .SHCP(shcp[1]), .STCP(stcp[1]), .busy(busy[1]), .done(done[1]));

  shift_chain_driver #(.NUM_BYTES(1), .CLK_DIV(1), .MSB_FIRST(1)) u_c (
    .clk(clk), .reset(rst_n), .start(start[2]), .data(data[2][7:0]),
    .ready(ready[2]), .DS(ds[2]), .SHCP(shcp[2]), .STCP(stcp[2]), .busy(busy[2]), .done(done[2]));

  typedef struct {
    int          inst;
    logic [15:0] bits;
    int          done_cyc;
    bit          chained;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [15:0] rx [3];
  int nrise [3], nhigh [3], nstcp [3], ds_bad [3], stcp_rise [3], done_cnt [3], post_st [3];
  bit chain_f [3];
  logic prev_shcp [3], prev_stcp [3], prev_ds [3];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wof(input int i);
    return (i == 1) ? 16 : 8;
  endfunction

  function automatic int cdiv(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
  endfunction

  function automatic logic [15:0] mask(input int i);
    return (i == 1) ? 16'hFFFF : 16'h00FF;
  endfunction

  function automatic int lat(input int i);
    return 1 + 2 * cdiv(i) * wof(i) + cdiv(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Pulse start for one cycle; data is scrambled right after accept.
  task automatic send(input int i, input logic [15:0] d, output int acc);
    @(posedge clk); #1;
    data[i]  = d;
    start[i] = 1'b1;
    acc      = cyc;
    exp_q.push_back('{inst: i, bits: d & mask(i), done_cyc: cyc + lat(i), chained: 1'b0});
    @(posedge clk); #1;
    start[i] = 1'b0;
    data[i]  = ~d;
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rx[i] = '0; nrise[i] = 0; nhigh[i] = 0; nstcp[i] = 0; ds_bad[i] = 0;
      stcp_rise[i] = 0; done_cnt[i] = 0; post_st[i] = 0; chain_f[i] = 1'b0;
      prev_shcp[i] = 1'b0; prev_stcp[i] = 1'b0; prev_ds[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          rx[i] = '0; nrise[i] = 0; nhigh[i] = 0; nstcp[i] = 0; ds_bad[i] = 0; post_st[i] = 0;
          prev_shcp[i] = 1'b0; prev_stcp[i] = 1'b0; prev_ds[i] = 1'b0;
        end else begin
          if (post_st[i] == 2) begin
            chk("chain_rearm", 32'({ready[i], busy[i]}), 32'b01);
            post_st[i] = 0;
          end else if (post_st[i] == 1) begin
            chk("after_done", 32'({ready[i], busy[i], done[i], ds[i], shcp[i], stcp[i]}), 32'b100000);
            post_st[i] = chain_f[i] ? 2 : 0;
          end
          if (shcp[i] && !prev_shcp[i]) begin
            nrise[i]++;
            if (i == 1) rx[i] = {ds[i], rx[i][15:1]};
            else        rx[i] = {rx[i][14:0], ds[i]} & mask(i);
          end
          if (shcp[i]) nhigh[i]++;
          if (stcp[i]) nstcp[i]++;
          if (stcp[i] && !prev_stcp[i]) stcp_rise[i]++;
          if ((shcp[i] || stcp[i]) && (prev_shcp[i] || prev_stcp[i]) && ds[i] !== prev_ds[i]) ds_bad[i]++;
          if (done[i]) begin
            done_cnt[i]++;
            if (exp_q.size() == 0) begin
              chk("unexpected_done", 32'(i), 32'hFFFF_FFFF);
            end else begin
              mon_e = exp_q.pop_front();
              chk("done_inst",  32'(i),      32'(mon_e.inst));
              chk("done_cycle", 32'(cyc),    32'(mon_e.done_cyc));
              chk("frame_bits", 32'(rx[i]),  32'(mon_e.bits));
              chk("shcp_rises", 32'(nrise[i]), 32'(wof(i)));
              chk("shcp_high_cycles", 32'(nhigh[i]), 32'(wof(i) * cdiv(i)));
              chk("stcp_width", 32'(nstcp[i]), 32'(cdiv(i)));
              chk("ds_stable_while_high", 32'(ds_bad[i]), 32'd0);
              chk("done_outputs", 32'({ds[i], stcp[i], shcp[i], busy[i], ready[i]}), 32'd0);
              chain_f[i] = mon_e.chained;
            end
            post_st[i] = 1;
            rx[i] = '0; nrise[i] = 0; nhigh[i] = 0; nstcp[i] = 0; ds_bad[i] = 0;
          end
          prev_shcp[i] = shcp[i];
          prev_stcp[i] = stcp[i];
          prev_ds[i]   = ds[i];
        end
      end
    end
  end

  initial begin
    int c0, d0, sr0, dc0, a2;
    logic [15:0] r;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      data[i]  = '0;
    end
    #12;
    for (int i = 0; i < 3; i++)
      chk("reset_state", 32'({ready[i], busy[i], done[i], ds[i], shcp[i], stcp[i]}), 32'b100000);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // 8'h69 MSB-first, CLK_DIV=4: done 69 cycles after accept
    send(0, 16'h0069, c0);
    wait_drain(400);

    // 16'hA5C3 LSB-first, CLK_DIV=2: done 67 cycles after accept
    send(1, 16'hA5C3, c0);
    wait_drain(400);

    // CLK_DIV=1 all-ones frame, plus a start pulse while busy that must be dropped
    d0 = done_cnt[2];
    send(2, 16'h00FF, c0);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_mid_frame", 32'(busy[2]), 32'd1);
    start[2] = 1'b1;
    data[2]  = 16'h0000;
    @(posedge clk); #1;
    start[2] = 1'b0;
    wait_drain(400);
    repeat (30) @(posedge clk);
    #1;
    chk("busy_start_ignored", 32'(done_cnt[2] - d0), 32'd1);

    // start held high across three frames
    @(posedge clk); #1;
    data[1]  = 16'h3C96;
    start[1] = 1'b1;
    c0       = cyc;
    for (int k = 0; k < 3; k++)
      exp_q.push_back('{inst: 1, bits: 16'h3C96, done_cyc: c0 + k * (lat(1) + 1) + lat(1), chained: (k < 2)});
    a2 = c0 + 2 * (lat(1) + 1);
    while (cyc < a2 + 1) begin
      @(posedge clk); #1;
    end
    start[1] = 1'b0;
    wait_drain(400);

    for (int k = 0; k < 6; k++) begin
      r = 16'($urandom);
      send(k % 3, r, c0);
      wait_drain(400);
    end

    // reset during the fifth bit's SHCP-high phase aborts the frame
    sr0 = stcp_rise[0];
    dc0 = done_cnt[0];
    send(0, 16'h000F, c0);
    while (cyc < c0 + 38) begin
      @(posedge clk); #1;
    end
    chk("pre_abort_shcp", 32'({shcp[0], ds[0]}), 32'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({ready[0], busy[0], done[0], ds[0], shcp[0], stcp[0]}), 32'b100000);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_stcp", 32'(stcp_rise[0]), 32'(sr0));
    chk("abort_no_done", 32'(done_cnt[0]), 32'(dc0));
    start[0] = 1'b1;
    data[0]  = 16'h00A7;
    #2;
    rst_n = 1'b1;
    exp_q.push_back('{inst: 0, bits: 16'h00A7, done_cyc: cyc + lat(0), chained: 1'b0});
    @(posedge clk); #1;
    start[0] = 1'b0;
    data[0]  = 16'h0058;
    wait_drain(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_chain_driver.md
SHIFT_CHAIN_DRIVER -- requirements
Module: shift_chain_driver

Interface
REQ-001 The block SHALL have parameter NUM_BYTES, default 2: number of cascaded 8-bit serial-in/parallel-out registers driven; legal range 1..16.
REQ-002 The block SHALL have parameter CLK_DIV, default 4: SHCP half-period, in clk cycles; legal range 1..255.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1: 1 shifts data[W-1] first, 0 shifts data[0] first (W = 8*NUM_BYTES).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-006 The block SHALL have port start, input, 1 bit: transfer request, sampled each cycle.
REQ-007 The block SHALL have port data, input, W bits: frame to shift, captured on the accept cycle.
REQ-008 The block SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-009 The block SHALL have port DS, output, 1 bit: serial data.
REQ-010 The block SHALL have port SHCP, output, 1 bit: shift clock.
REQ-011 The block SHALL have port STCP, output, 1 bit: storage latch clock.
REQ-012 The block SHALL have port busy, output, 1 bit: high from the cycle after accept until done is asserted.
REQ-013 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-014 All outputs SHALL be registered, with no combinational path from start or data to any output.
REQ-015 The FSM SHALL have states IDLE, SH_LOW, SH_HIGH, LATCH and DONE.
REQ-016 Accept: in IDLE with start=1, the block SHALL capture data into a W-bit shift register and enter SH_LOW on the next edge; start in any other state SHALL be ignored and not queued.
REQ-017 SH_LOW SHALL last CLK_DIV cycles with SHCP=0; DS SHALL be updated to the next bit only on entry to SH_LOW, giving CLK_DIV cycles of setup before the SHCP rise.
REQ-018 SH_HIGH SHALL last CLK_DIV cycles with SHCP=1 and DS held stable; exit goes to SH_LOW if bits remain, otherwise to LATCH.
REQ-019 The bit counter SHALL count exactly W SH_LOW/SH_HIGH pairs and be sized $clog2(W+1).
REQ-020 LATCH SHALL last CLK_DIV cycles with SHCP=0 and STCP=1; DS SHALL hold the last bit.
REQ-021 DONE SHALL last one cycle with done=1, STCP=0, DS=0, then return to IDLE; ready SHALL be 1 in the following cycle.
REQ-022 Latency: with the accept in cycle 0, done SHALL be high in cycle 1 + 2*CLK_DIV*W + CLK_DIV exactly.
REQ-023 Back-to-back: start held high SHALL be accepted again in the first IDLE cycle after DONE, giving a minimum frame spacing of one IDLE cycle.
REQ-024 A change of data after the accept SHALL NOT affect the frame in flight.
REQ-025 The phase counter SHALL reload at every state entry and never wrap; with CLK_DIV=1, every phase SHALL last exactly one cycle.

Reset
REQ-026 With reset=0, the block SHALL go to IDLE immediately, asynchronously: DS=0, SHCP=0, STCP=0, busy=0, done=0, ready=1, counters and shift register cleared.
REQ-027 Reset mid-transfer SHALL abort the transfer with no STCP pulse and no done pulse.
REQ-028 Reset release SHALL take effect at the next clk edge, and a start on that edge SHALL be accepted.

Structure
REQ-029 Package shift_chain_pkg SHALL hold the state enum, the phase-counter width constant (8 bits) and a bit-counter width function.
REQ-030 Sub-module phase_timer SHALL implement the loadable down-counter (load value, terminal-count flag), instanced once.
REQ-031 Elaboration SHALL fail for parameters outside their legal range.

Verification
REQ-032 Scenario (NUM_BYTES=1, CLK_DIV=4, MSB_FIRST=1): data=8'h69, pulse start -> DS sampled at the 8 SHCP rises = 0,1,1,0,1,0,0,1; one STCP pulse 4 cycles wide; done in cycle 69.
REQ-033 Scenario (NUM_BYTES=2, CLK_DIV=2, MSB_FIRST=0): data=16'hA5C3 -> LSB-first bits equal 16'hA5C3; done in cycle 67.
REQ-034 Scenario: start pulsed again while busy -> exactly one frame is shifted and one done pulse is produced.
REQ-035 Scenario: start held high for 3 frames -> three done pulses 1+2*CLK_DIV*W+CLK_DIV+1 cycles apart, and ready high for exactly one cycle between frames.
REQ-036 Scenario: reset=0 during bit 5 of a frame -> all outputs are 0 in the same cycle (ready=1), STCP never rises, and a fresh frame afterwards is correct.
REQ-037 Scenario (CLK_DIV=1): data=8'hFF -> SHCP toggles every cycle, there are 8 rises, and done occurs in cycle 18.
